pid_loop_sequencer: RTL



---
 rtl/pid_loop_sequencer_if.sv | 56 +++++
 rtl/pid_loop_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pid_loop_sequencer_if.sv
// pid_loop_sequencer_if: bundles config, run control, PID-core handshake and status.
// Latency: none (wires only).
// Backpressure: cfg_valid/cfg_ready handshake; core side is pulse/strobe based.
// master: the sequencer side. slave: the environment (config source, core, consumer).
interface pid_loop_sequencer_if #(
    parameter int D_WIDTH  = 16,
    parameter int PERIOD_W = 16
);
    // configuration port
    logic                cfg_valid;
    logic                cfg_ready;
    logic [1:0]          cfg_addr;
    logic [D_WIDTH-1:0]  cfg_data;
    // run control and samples
    logic                start;
    logic                stop;
    logic [PERIOD_W-1:0] period;
    logic [D_WIDTH-1:0]  target_in;
    logic [D_WIDTH-1:0]  meas_in;
    // PID core side
    logic                pid_write_enable;
    logic                pid_iterate_enable;
    logic [D_WIDTH-1:0]  pid_reg_addr;
    logic [D_WIDTH-1:0]  pid_reg_data;
    logic [D_WIDTH-1:0]  pid_target;
    logic [D_WIDTH-1:0]  pid_measurement;
    logic [D_WIDTH-1:0]  pid_out;
    logic                pid_out_valid;
    // published result and status
    logic [D_WIDTH-1:0]  ctrl_out;
    logic                ctrl_valid;
    logic                ctrl_sat;
    logic [7:0]          overrun_cnt;
    logic                timeout_err;
    logic                running;

    modport master (
        input  cfg_valid, cfg_addr, cfg_data,
        input  start, stop, period, target_in, meas_in,
        input  pid_out, pid_out_valid,
        output cfg_ready,
        output pid_write_enable, pid_iterate_enable, pid_reg_addr, pid_reg_data,
        output pid_target, pid_measurement,
        output ctrl_out, ctrl_valid, ctrl_sat, overrun_cnt, timeout_err, running
    );

    modport slave (
        output cfg_valid, cfg_addr, cfg_data,
        output start, stop, period, target_in, meas_in,
        output pid_out, pid_out_valid,
        input  cfg_ready,
        input  pid_write_enable, pid_iterate_enable, pid_reg_addr, pid_reg_data,
        input  pid_target, pid_measurement,
        input  ctrl_out, ctrl_valid, ctrl_sat, overrun_cnt, timeout_err, running
    );
endinterface

// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: loads gains into one PID core while idle, then paces it with a
//   one-cycle iterate pulse every `period` cycles and publishes the clamped result.
// Latency: all outputs registered; ctrl_valid strobes one cycle after pid_out_valid.
// Backpressure: cfg_ready high only in IDLE; a tick arriving while a result is still
//   outstanding is dropped and counted in overrun_cnt (saturating at 255).
// Ports: clk, rst (synchronous, active-high); bus = master side of pid_loop_sequencer_if
//   (config write port, start/stop/period/samples, core handshake, ctrl_out + status).
module pid_loop_sequencer #(
    parameter int D_WIDTH  = 16,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 32,
    parameter int LIM_MAX  = 4096,
    parameter int LIM_MIN  = -4096
) (
    input  logic                 clk,
    input  logic                 rst,
    pid_loop_sequencer_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic signed [D_WIDTH-1:0] LIM_MAX_S = D_WIDTH'(LIM_MAX);
    localparam logic signed [D_WIDTH-1:0] LIM_MIN_S = D_WIDTH'(LIM_MIN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_WAIT = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                we_q, we_d;
    logic                iter_q, iter_d;
    logic [D_WIDTH-1:0]  reg_addr_q, reg_addr_d;
    logic [D_WIDTH-1:0]  reg_data_q, reg_data_d;
    logic [D_WIDTH-1:0]  tgt_q, tgt_d;
    logic [D_WIDTH-1:0]  meas_q, meas_d;
    logic [D_WIDTH-1:0]  ctrl_out_q, ctrl_out_d;
    logic                ctrl_vld_q, ctrl_vld_d;
    logic                ctrl_sat_q, ctrl_sat_d;
    logic [7:0]          ovr_q, ovr_d;
    logic                terr_q, terr_d;
    logic                running_q, running_d;

    logic                      tick;
    logic signed [D_WIDTH-1:0] res_s;
    logic [D_WIDTH-1:0]        res_clamped;
    logic                      res_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            per_q       <= '0;
            to_q        <= '0;
            cfg_ready_q <= 1'b1;
            we_q        <= 1'b0;
            iter_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            tgt_q       <= '0;
            meas_q      <= '0;
            ctrl_out_q  <= '0;
            ctrl_vld_q  <= 1'b0;
            ctrl_sat_q  <= 1'b0;
            ovr_q       <= '0;
            terr_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            to_q        <= to_d;
            cfg_ready_q <= cfg_ready_d;
            we_q        <= we_d;
            iter_q      <= iter_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            tgt_q       <= tgt_d;
            meas_q      <= meas_d;
            ctrl_out_q  <= ctrl_out_d;
            ctrl_vld_q  <= ctrl_vld_d;
            ctrl_sat_q  <= ctrl_sat_d;
            ovr_q       <= ovr_d;
            terr_q      <= terr_d;
            running_q   <= running_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        to_d        = to_q;
        iter_d      = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        tgt_d       = tgt_q;
        meas_d      = meas_q;
        ctrl_out_d  = ctrl_out_q;
        ctrl_vld_d  = 1'b0;
        ctrl_sat_d  = ctrl_sat_q;
        ovr_d       = ovr_q;
        terr_d      = terr_q;

        // The latched period is never 0, so the counter reaching 1 marks a tick.
        tick = (cnt_q == PERIOD_W'(1));

        res_s       = bus.pid_out;
        res_clamped = bus.pid_out;
        res_hit     = 1'b0;
        if (res_s > LIM_MAX_S) begin
            res_clamped = LIM_MAX_S;
            res_hit     = 1'b1;
        end else if (res_s < LIM_MIN_S) begin
            res_clamped = LIM_MIN_S;
            res_hit     = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // A config write takes priority over start; stop vetoes start.
                if (bus.cfg_valid) begin
                    reg_addr_d = D_WIDTH'(bus.cfg_addr);
                    reg_data_d = bus.cfg_data;
                end else if (bus.start && !bus.stop) begin
                    per_d   = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
                    cnt_d   = per_d;
                    terr_d  = 1'b0;
                    ovr_d   = '0;
                    state_d = RUN_WAIT;
                end
            end

            RUN_WAIT: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    tgt_d   = bus.target_in;
                    meas_d  = bus.meas_in;
                    iter_d  = 1'b1;
                    cnt_d   = per_q;
                    to_d    = '0;
                    state_d = WAIT_RES;
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end

            WAIT_RES: begin
                // stop discards any result landing in the same cycle.
                if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    // The pace keeps running; a tick here is dropped as an overrun,
                    // even when the result arrives in that same cycle.
                    if (tick) begin
                        cnt_d = per_q;
                        if (ovr_q != 8'hFF) begin
                            ovr_d = ovr_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - PERIOD_W'(1);
                    end
                    to_d = to_q + TO_W'(1);
                    if (bus.pid_out_valid) begin
                        ctrl_out_d = res_clamped;
                        ctrl_sat_d = res_hit;
                        ctrl_vld_d = 1'b1;
                        state_d    = RUN_WAIT;
                    end else if (to_d == TO_W'(TIMEOUT)) begin
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Mode outputs follow the next state so they line up with it after the edge;
        // dropping write_enable on the way to IDLE holds the core in reset.
        cfg_ready_d = (state_d == IDLE);
        running_d   = (state_d != IDLE);
        we_d        = (state_d != IDLE);
    end

    assign bus.cfg_ready          = cfg_ready_q;
    assign bus.pid_write_enable   = we_q;
    assign bus.pid_iterate_enable = iter_q;
    assign bus.pid_reg_addr       = reg_addr_q;
    assign bus.pid_reg_data       = reg_data_q;
    assign bus.pid_target         = tgt_q;
    assign bus.pid_measurement    = meas_q;
    assign bus.ctrl_out           = ctrl_out_q;
    assign bus.ctrl_valid         = ctrl_vld_q;
    assign bus.ctrl_sat           = ctrl_sat_q;
    assign bus.overrun_cnt        = ovr_q;
    assign bus.timeout_err        = terr_q;
    assign bus.running            = running_q;

endmodule
